// File: rtl/rv32c_fetch_aligner_pkg.sv
// rv32c_pkg: shared definitions for the RV32C fetch aligner.
//   state_e   - aligner FSM states (S_RUN / S_HC / S_HS)
//   OP_32     - low two opcode bits marking a 32-bit instruction
//   C_ILLEGAL - the all-zero compressed parcel, architecturally illegal
//   is_c()    - compressed-parcel test
package rv32c_pkg;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,  // nothing held
    S_HC  = 2'd1,  // HOLD is a complete compressed instruction
    S_HS  = 2'd2   // HOLD is the low half of a 32-bit instruction
  } state_e;

  localparam logic [1:0]  OP_32     = 2'b11;
  localparam logic [15:0] C_ILLEGAL = 16'h0000;

  function automatic logic is_c(input logic [15:0] parcel);
    return parcel[1:0] != OP_32;
  endfunction

endpackage

// File: rtl/rv32c_fetch_aligner.sv
// rv32c_fetch_aligner: splits word-aligned 32-bit fetch words into 16-bit
// compressed and 32-bit instructions (including ones straddling two words)
// and hands them one at a time to decode with their PC. Owns the fetch
// address: sequential advance plus redirect.
//
// Ports:
//   iCLK, iRST            clock, synchronous active-high reset
//   oF_ADDR/oF_READY      fetch request address (word aligned) / ready
//   iF_VALID/iF_DATA      fetched word for oF_ADDR
//   iREDIR/iREDIR_PC      flush and restart at iREDIR_PC (bit 0 ignored)
//   oI_VALID/iI_READY     instruction handshake
//   oI_INSN/oI_PC/oI_IS_C instruction, its PC, compressed flag
//   oI_ILLEGAL            only with RV32C_ILLEGAL_CHECK_EN: emitted
//                         instruction is the all-zero compressed parcel
//
// Build option: define RV32C_ILLEGAL_CHECK_EN to add oI_ILLEGAL.
module rv32c_fetch_aligner
  import rv32c_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            iCLK,
  input  logic            iRST,
  output logic [PC_W-1:0] oF_ADDR,
  output logic            oF_READY,
  input  logic            iF_VALID,
  input  logic [31:0]     iF_DATA,
  input  logic            iREDIR,
  input  logic [PC_W-1:0] iREDIR_PC,
  output logic            oI_VALID,
  input  logic            iI_READY,
  output logic [31:0]     oI_INSN,
  output logic [PC_W-1:0] oI_PC,
  output logic            oI_IS_C
`ifdef RV32C_ILLEGAL_CHECK_EN
  ,
  output logic            oI_ILLEGAL
`endif
);

  state_e          state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;
  logic            skip_q, skip_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic            vld_q, vld_d;
  logic [31:0]     insn_q, insn_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            isc_q, isc_d;

  logic            out_free, f_acc, emit;
  logic [31:0]     e_insn;
  logic [PC_W-1:0] e_pc, pc_a2;
  logic [15:0]     p0, p1;

  // Bit 0 of the redirect target is meaningless for 16-bit aligned code.
  logic unused_redir_b0;
  assign unused_redir_b0 = iREDIR_PC[0];

  assign p0       = iF_DATA[15:0];
  assign p1       = iF_DATA[31:16];
  assign pc_a2    = addr_q + PC_W'(2);
  assign out_free = !vld_q || iI_READY;
  // S_HC drains HOLD without fetching, so no word can be taken then.
  assign oF_READY = out_free && (state_q != S_HC) && !iREDIR;
  assign f_acc    = iF_VALID && oF_READY;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    skip_d    = skip_q;
    addr_d    = addr_q;
    vld_d     = vld_q && !iI_READY;
    insn_d    = insn_q;
    pc_d      = pc_q;
    isc_d     = isc_q;
    emit      = 1'b0;
    e_insn    = '0;
    e_pc      = '0;

    if (iREDIR) begin
      // Flush everything, including an output the consumer is taking now.
      vld_d   = 1'b0;
      state_d = S_RUN;
      addr_d  = {iREDIR_PC[PC_W-1:2], 2'b00};
      skip_d  = iREDIR_PC[1];
    end else begin
      if (f_acc) addr_d = addr_q + PC_W'(4);
      unique case (state_q)
        S_RUN: begin
          if (f_acc) begin
            if (skip_q) begin
              // Entered mid-word: only parcel1 belongs to the stream.
              skip_d = 1'b0;
              if (is_c(p1)) begin
                emit   = 1'b1;
                e_insn = {16'h0000, p1};
                e_pc   = pc_a2;
              end else begin
                hold_d    = p1;
                hold_pc_d = pc_a2;
                state_d   = S_HS;
              end
            end else if (!is_c(p0)) begin
              emit   = 1'b1;
              e_insn = iF_DATA;
              e_pc   = addr_q;
            end else begin
              emit      = 1'b1;
              e_insn    = {16'h0000, p0};
              e_pc      = addr_q;
              hold_d    = p1;
              hold_pc_d = pc_a2;
              state_d   = is_c(p1) ? S_HC : S_HS;
            end
          end
        end
        S_HC: begin
          if (out_free) begin
            emit    = 1'b1;
            e_insn  = {16'h0000, hold_q};
            e_pc    = hold_pc_q;
            state_d = S_RUN;
          end
        end
        S_HS: begin
          if (f_acc) begin
            // Complete the straddling instruction; parcel1 becomes the new hold.
            emit      = 1'b1;
            e_insn    = {p0, hold_q};
            e_pc      = hold_pc_q;
            hold_d    = p1;
            hold_pc_d = pc_a2;
            state_d   = is_c(p1) ? S_HC : S_HS;
          end
        end
        default: state_d = S_RUN;
      endcase
      if (emit) begin
        vld_d  = 1'b1;
        insn_d = e_insn;
        pc_d   = e_pc;
        isc_d  = is_c(e_insn[15:0]);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= S_RUN;
      hold_q    <= '0;
      hold_pc_q <= '0;
      skip_q    <= 1'b0;
      addr_q    <= {RESET_PC[PC_W-1:2], 2'b00};
      vld_q     <= 1'b0;
      insn_q    <= '0;
      pc_q      <= '0;
      isc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      skip_q    <= skip_d;
      addr_q    <= addr_d;
      vld_q     <= vld_d;
      insn_q    <= insn_d;
      pc_q      <= pc_d;
      isc_q     <= isc_d;
    end
  end

  assign oF_ADDR  = addr_q;
  assign oI_VALID = vld_q;
  assign oI_INSN  = insn_q;
  assign oI_PC    = pc_q;
  assign oI_IS_C  = isc_q;

`ifdef RV32C_ILLEGAL_CHECK_EN
  logic ill_q, ill_d;

  // Flag follows the instruction register: reloaded only on emit.
  always_comb begin
    ill_d = ill_q;
    if (!iREDIR && emit)
      ill_d = is_c(e_insn[15:0]) && (e_insn[15:0] == C_ILLEGAL);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) ill_q <= 1'b0;
    else      ill_q <= ill_d;
  end

  assign oI_ILLEGAL = ill_q;
`else
  // No illegal-parcel detection in this build.
`endif

endmodule

// File: tb/tb_rv32c_fetch_aligner.sv
module tb_rv32c_fetch_aligner;

  logic        iCLK, iRST;
  logic [31:0] oF_ADDR;
  logic        oF_READY, iF_VALID;
  logic [31:0] iF_DATA;
  logic        iREDIR;
  logic [31:0] iREDIR_PC;
  logic        oI_VALID, iI_READY;
  logic [31:0] oI_INSN, oI_PC;
  logic        oI_IS_C;
`ifdef RV32C_ILLEGAL_CHECK_EN
  logic        oI_ILLEGAL;
`endif

  rv32c_fetch_aligner #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oF_ADDR(oF_ADDR), .oF_READY(oF_READY),
    .iF_VALID(iF_VALID), .iF_DATA(iF_DATA),
    .iREDIR(iREDIR), .iREDIR_PC(iREDIR_PC),
    .oI_VALID(oI_VALID), .iI_READY(iI_READY),
    .oI_INSN(oI_INSN), .oI_PC(oI_PC), .oI_IS_C(oI_IS_C)
`ifdef RV32C_ILLEGAL_CHECK_EN
    , .oI_ILLEGAL(oI_ILLEGAL)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        isc;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem[0:255];
  logic [31:0] exp_fa;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Instruction memory image: byte address -> 16-bit parcel.
  function automatic logic [15:0] parcel_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[9:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic void push_exp(input logic [31:0] insn, input logic [31:0] pc, input logic isc);
    exp_t e;
    e.insn = insn; e.pc = pc; e.isc = isc;
    e.ill  = isc && (insn[15:0] == 16'h0000);
    q.push_back(e);
  endfunction

  // Reference: walk the program as a parcel stream from a start PC.
  function automatic void model_walk(input logic [31:0] start, input int n);
    logic [31:0] pc;
    logic [15:0] a, b;
    pc = start;
    for (int i = 0; i < n; i++) begin
      a = parcel_at(pc);
      if (a[1:0] != 2'b11) begin
        push_exp({16'h0, a}, pc, 1'b1);
        pc = pc + 32'd2;
      end else begin
        b = parcel_at(pc + 32'd2);
        push_exp({b, a}, pc, 1'b0);
        pc = pc + 32'd4;
      end
    end
  endfunction

  // One cycle: drive at negedge, check handshakes just before the posedge.
  task automatic step(input logic fv, input logic rdy, output logic fired);
    exp_t e;
    @(negedge iCLK);
    iF_VALID = fv;
    iI_READY = rdy;
    iF_DATA  = mem[oF_ADDR[9:2]];
    #1;
    fired = oI_VALID && iI_READY;
    if (iF_VALID && oF_READY) begin
      n_tests++;
      if (oF_ADDR !== exp_fa) begin
        n_fail++;
        $display("FAIL fetch_addr: got %h want %h", oF_ADDR, exp_fa);
      end
      exp_fa = exp_fa + 32'd4;
    end
    if (fired) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_insn: got %h at pc %h want none", oI_INSN, oI_PC);
      end else begin
        e = q.pop_front();
        if (oI_INSN !== e.insn || oI_PC !== e.pc || oI_IS_C !== e.isc) begin
          n_fail++;
          $display("FAIL insn: got %h pc %h c %b want %h pc %h c %b",
                   oI_INSN, oI_PC, oI_IS_C, e.insn, e.pc, e.isc);
        end
`ifdef RV32C_ILLEGAL_CHECK_EN
        n_tests++;
        if (oI_ILLEGAL !== e.ill) begin
          n_fail++;
          $display("FAIL illegal: got %b want %b at pc %h", oI_ILLEGAL, e.ill, e.pc);
        end
`endif
      end
    end
  endtask

  task automatic run_until(input int budget, input int vpct, input int rpct);
    int   cyc;
    logic f;
    cyc = 0;
    while (q.size() != 0 && cyc < budget) begin
      step($urandom_range(0, 99) < vpct, $urandom_range(0, 99) < rpct, f);
      cyc++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d insns outstanding want 0", q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST = 1'b1; iF_VALID = 1'b0; iREDIR = 1'b0; iI_READY = 1'b0;
    @(negedge iCLK);
    iRST = 1'b0;
    q.delete();
    exp_fa = 32'h0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(negedge iCLK);
    iREDIR = 1'b1; iREDIR_PC = pc;
    iF_VALID = 1'($urandom); iI_READY = 1'($urandom);
    iF_DATA = mem[oF_ADDR[9:2]];
    @(posedge iCLK);
    #1;
    iREDIR = 1'b0;
    q.delete();
    exp_fa = {pc[31:2], 2'b00};
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (oF_ADDR !== 32'h0 || oI_VALID !== 1'b0 || oI_INSN !== 32'h0 ||
        oI_PC !== 32'h0 || oI_IS_C !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: addr %h vld %b insn %h pc %h c %b want all 0",
               oF_ADDR, oI_VALID, oI_INSN, oI_PC, oI_IS_C);
    end
    n_tests++;
    if (oF_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", oF_READY);
    end
  endtask

  task automatic test_basic32();
    logic f;
    mem[0] = 32'h0000_0013; mem[1] = 32'h0010_0093;
    do_reset();
    push_exp(32'h0000_0013, 32'h0, 1'b0);
    push_exp(32'h0010_0093, 32'h4, 1'b0);
    step(1'b1, 1'b1, f);
    n_tests++;
    if (f !== 1'b0) begin n_fail++; $display("FAIL b32_early: got %b want 0", f); end
    step(1'b0, 1'b1, f);
    n_tests++;
    if (f !== 1'b1) begin n_fail++; $display("FAIL b32_lat0: got %b want 1", f); end
    step(1'b1, 1'b1, f);
    step(1'b0, 1'b1, f);
    n_tests++;
    if (f !== 1'b1) begin n_fail++; $display("FAIL b32_lat1: got %b want 1", f); end
    run_until(10, 100, 100);
  endtask

  task automatic test_compressed();
    logic f;
    mem[0] = 32'h4501_C119;
    do_reset();
    push_exp(32'h0000_C119, 32'h0, 1'b1);
    push_exp(32'h0000_4501, 32'h2, 1'b1);
    step(1'b1, 1'b1, f);
    step(1'b1, 1'b1, f);
    n_tests++;
    if (oF_READY !== 1'b0) begin n_fail++; $display("FAIL hc_ready: got %b want 0", oF_READY); end
    run_until(10, 0, 100);
  endtask

  task automatic test_split();
    mem[0] = 32'h0013_4501; mem[1] = 32'h0000_0013;
    do_reset();
    push_exp(32'h0000_4501, 32'h0, 1'b1);
    push_exp(32'h0013_0013, 32'h2, 1'b0);
    push_exp(32'h0000_0000, 32'h6, 1'b1);
    run_until(20, 100, 100);
  endtask

  task automatic test_redirect();
    logic f;
    mem[0] = 32'h0000_0013;
    mem[8'h40] = 32'h4501_C119; mem[8'h41] = 32'h0000_0013; mem[8'h42] = 32'h0010_0093;
    do_reset();
    step(1'b1, 1'b1, f);
    @(negedge iCLK);
    iREDIR = 1'b1; iREDIR_PC = 32'h102; iF_VALID = 1'b1; iI_READY = 1'b1;
    iF_DATA = mem[oF_ADDR[9:2]];
    #1;
    n_tests++;
    if (oI_VALID !== 1'b1 || oF_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_pre: vld %b rdy %b want 1 0", oI_VALID, oF_READY);
    end
    @(posedge iCLK);
    #1;
    iREDIR = 1'b0;
    n_tests++;
    if (oI_VALID !== 1'b0 || oF_ADDR !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_post: vld %b addr %h want 0 00000100", oI_VALID, oF_ADDR);
    end
    q.delete();
    exp_fa = 32'h100;
    model_walk(32'h102, 3);
    run_until(30, 100, 100);
  endtask

  task automatic test_backpressure();
    logic        f;
    logic [31:0] ci, cp;
    mem[0] = 32'h0000_0013; mem[1] = 32'h4501_C119;
    mem[2] = 32'h0013_4501; mem[3] = 32'h0000_0013;
    do_reset();
    model_walk(32'h0, 6);
    step(1'b1, 1'b1, f);
    step(1'b1, 1'b0, f);
    ci = oI_INSN; cp = oI_PC;
    n_tests++;
    if (oI_VALID !== 1'b1 || oF_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_start: vld %b rdy %b want 1 0", oI_VALID, oF_READY);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, f);
      n_tests++;
      if (oI_VALID !== 1'b1 || oF_READY !== 1'b0 || oI_INSN !== ci || oI_PC !== cp) begin
        n_fail++;
        $display("FAIL bp_hold: vld %b rdy %b insn %h pc %h want 1 0 %h %h",
                 oI_VALID, oF_READY, oI_INSN, oI_PC, ci, cp);
      end
    end
    run_until(60, 100, 100);
  endtask

  task automatic test_random();
    logic [31:0] w, start;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 256; i++) begin
        w = $urandom;
        if ($urandom_range(0, 1) == 1) w[1:0]   = 2'b11;
        if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
        mem[i] = w;
      end
      start = (r == 4) ? 32'hFFFF_FFF6 : {22'h0, 9'($urandom_range(0, 511)), 1'b0};
      do_redirect(start);
      model_walk(start, 80);
      run_until(3000, 60, 60);
    end
  endtask

`ifdef RV32C_ILLEGAL_CHECK_EN
  task automatic test_illegal();
    mem[0] = 32'h0000_0000;
    do_reset();
    push_exp(32'h0, 32'h0, 1'b1);
    push_exp(32'h0, 32'h2, 1'b1);
    run_until(20, 100, 100);
  endtask
`endif

  initial begin
    iRST = 1'b1; iF_VALID = 1'b0; iF_DATA = '0; iREDIR = 1'b0;
    iREDIR_PC = '0; iI_READY = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    test_reset();
    test_basic32();
    test_compressed();
    test_split();
    test_redirect();
    test_backpressure();
    test_random();
`ifdef RV32C_ILLEGAL_CHECK_EN
    test_illegal();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
